dispense_scheduler: RTL and testbench
=====================================

# dispense_scheduler

Sequences the pill-dispenser actuators from the dose-time pulses, the per-module dose masks and the manual overrides. All actuators share one drive supply, so the block grants them one at a time with round-robin fairness. Each grant produces a fixed-length actuator pulse followed by a mandatory gap. It sits between the dose-time generator / dispense setter / override logic and the LEDR/GPIO actuator pins, and it supplies the alarm enable.

## Interface
- N_MOD, 2, number of dispenser modules (≥1)
- PULSE_CYC, 50_000_000, actuator on-time in clock cycles (≥1)
- GAP_CYC, 25_000_000, forced off-time after each pulse in cycles (≥1)

- CLOCK_50  in  1  system clock, single clock domain
- reset  in  1  asynchronous, active-high; clears all state
- morningP / afternoonP / eveningP  in  1 each  single-cycle dose-slot pulses
- sched_mask  in  3*N_MOD  module i mask at [3i+2:3i] = {evening, afternoon, morning}
- override  in  N_MOD  level; a rising edge requests one dose for that module
- enable  in  1  grant permission; requests are still latched while low
- act_out  out  N_MOD  one-hot actuator drive
- pending  out  N_MOD  latched, not-yet-served requests
- busy  out  1  state ≠ IDLE
- alarm  out  1  |pending OR busy
- dose_count  out  8  doses issued, saturating at 255

## Operation
- Request sources per module i:
  - (morningP & mask[3i]) | (afternoonP & mask[3i+1]) | (eveningP & mask[3i+2])
  - override[i] rising edge (ov_prev resets to all-ones, so an override held through reset does not fire)
- Request at edge t sets pending[i] after edge t.
- A request for an already-pending module merges: no double dose.
- A request for the module currently in PULSE sets pending again, queuing one more dose.
- FSM states: IDLE, PULSE, GAP.
  - IDLE: if enable and |pending, the round-robin winner g gets act_out[g]=1, pending[g] is cleared, dose_count increments, go to PULSE. Otherwise stay.
  - PULSE: counter runs PULSE_CYC cycles with act_out one-hot, then go to GAP and set act_out=0.
  - GAP: counter runs GAP_CYC cycles, then go to IDLE.
- Round robin: the pointer holds the last granted index. Search starts at pointer+1 modulo N_MOD. Reset value is N_MOD-1, so module 0 wins first.
- enable dropping mid-PULSE/GAP: the current sequence completes and no new grant is made.
- act_out is never more than one-hot. All-zero outside PULSE.
- Counter width: $clog2(max(PULSE_CYC, GAP_CYC)+1), unsigned, reloaded on every state entry.
- dose_count saturates at 255. It never wraps.

## Timing
- Reset values: act_out=0, pending=0, busy=0, alarm=0, dose_count=0, state=IDLE, pointer=N_MOD-1.
- Reset acts immediately (asynchronously) on every output.
- Latency: slot pulse at edge t → pending after t → act_out high from edge t+1.
- act_out stays high for exactly PULSE_CYC cycles, then low for GAP_CYC cycles, then one IDLE cycle.
- Back-to-back grant spacing is therefore PULSE_CYC+GAP_CYC+1 cycles.
- A request arriving in the same cycle as an IDLE grant is latched and served in a later sequence.
- All outputs are registered except alarm, which is a single OR of registered signals.

## Structure
- Package dispense_pkg holds:
  - state enum {IDLE, PULSE, GAP}
  - slot indices SLOT_MORNING=0, SLOT_AFTERNOON=1, SLOT_EVENING=2
  - DOSE_CNT_W=8
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs one-hot gnt[N] and gnt_idx. Purely combinational.
- Request latching, edge detection, the FSM, the counter and statistics stay in dispense_scheduler.

## Test plan
Use PULSE_CYC=4, GAP_CYC=2, N_MOD=2 throughout.
- Reset → act_out=00, pending=00, alarm=0, dose_count=0. Assert reset again mid-PULSE → act_out=00 immediately; pending and count clear.
- mask={000,001}, morningP at edge t → pending=01 after t; act_out=01 for cycles t+1..t+4; 00 for t+5..t+6; IDLE at t+7; dose_count=1; alarm falls at t+7.
- Both masks=001, morningP → act_out=01 for 4 cycles, 00 for 3 cycles, then 10 for 4 cycles; dose_count=2. A second morningP before the first grant → still only 2 doses.
- override[1] rises while module 0 is in PULSE → module 1 is granted right after module 0's gap+IDLE. override held high 100 cycles → exactly one dose.
- enable=0 with pending=11 → act_out stays 00, alarm=1, busy=0. Raise enable at edge u → act_out=01 from u+1, then module 1 after the spacing.
- 300 override edges on module 0 → dose_count reads 255 and stays 255.

Source files
------------

// File: rtl/dispense_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispense_pkg
// Description : Shared types and constants for the pill-dispense scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package dispense_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int SLOT_MORNING   = 0;
    localparam int SLOT_AFTERNOON = 1;
    localparam int SLOT_EVENING   = 2;
    localparam int DOSE_CNT_W     = 8;

    // Index width that stays legal for a single-module build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispense_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick; search starts after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import dispense_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    int   w_idx;
    logic w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(ptr) + k) % N;
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = IDX_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dispense_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dispense_scheduler
// Description : Latches dose requests and grants actuators one at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module dispense_scheduler
    import dispense_pkg::*;
#(
    parameter int N_MOD     = 2,
    parameter int PULSE_CYC = 50_000_000,
    parameter int GAP_CYC   = 25_000_000
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  morningP,
    input  logic                  afternoonP,
    input  logic                  eveningP,
    input  logic [3*N_MOD-1:0]    sched_mask,
    input  logic [N_MOD-1:0]      override,
    input  logic                  enable,
    output logic [N_MOD-1:0]      act_out,
    output logic [N_MOD-1:0]      pending,
    output logic                  busy,
    output logic                  alarm,
    output logic [DOSE_CNT_W-1:0] dose_count
);

    localparam int c_IDX_W   = idx_width(N_MOD);
    localparam int c_CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LOAD = c_CNT_W'(PULSE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD   = c_CNT_W'(GAP_CYC - 1);

    state_t                  r_state, w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [N_MOD-1:0]        r_pending, w_pending_nxt, w_pending_clr;
    logic [N_MOD-1:0]        r_act, w_act_nxt;
    logic [N_MOD-1:0]        r_ov_prev;
    logic [c_IDX_W-1:0]      r_ptr, w_ptr_nxt;
    logic [DOSE_CNT_W-1:0]   r_count, w_count_nxt;
    logic                    r_busy;
    logic [N_MOD-1:0]        w_slot_req, w_ov_rise, w_gnt;
    logic [c_IDX_W-1:0]      w_gnt_idx;

    generate
        for (genvar i = 0; i < N_MOD; i++) begin : g_slot_req
            assign w_slot_req[i] = (morningP   & sched_mask[3*i + SLOT_MORNING])
                                 | (afternoonP & sched_mask[3*i + SLOT_AFTERNOON])
                                 | (eveningP   & sched_mask[3*i + SLOT_EVENING]);
        end
    endgenerate

    assign w_ov_rise = override & ~r_ov_prev;

    rr_arbiter #(
        .N     (N_MOD),
        .IDX_W (c_IDX_W)
    ) u_arb (
        .req     (r_pending),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_act_nxt     = r_act;
        w_ptr_nxt     = r_ptr;
        w_count_nxt   = r_count;
        w_pending_clr = '0;
        case (r_state)
            IDLE: begin
                if (enable && (|r_pending)) begin
                    w_state_nxt   = PULSE;
                    w_cnt_nxt     = c_PULSE_LOAD;
                    w_act_nxt     = w_gnt;
                    w_ptr_nxt     = w_gnt_idx;
                    w_pending_clr = w_gnt;
                    w_count_nxt   = (r_count == '1) ? r_count : r_count + 1'b1;
                end
            end
            PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = c_GAP_LOAD;
                    w_act_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_act_nxt   = '0;
            end
        endcase
        // New requests land after the grant clear, so a same-cycle request re-queues.
        w_pending_nxt = (r_pending & ~w_pending_clr) | w_slot_req | w_ov_rise;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_act     <= '0;
            r_ov_prev <= '1;
            r_ptr     <= c_IDX_W'(N_MOD - 1);
            r_count   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_act     <= w_act_nxt;
            r_ov_prev <= override;
            r_ptr     <= w_ptr_nxt;
            r_count   <= w_count_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    assign act_out    = r_act;
    assign pending    = r_pending;
    assign busy       = r_busy;
    assign dose_count = r_count;
    assign alarm      = (|r_pending) | r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dispense_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispense_scheduler
// Description : Randomised/directed bench against a timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispense_scheduler;

    localparam int N = 2;
    localparam int P = 4;
    localparam int G = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           morningP, afternoonP, eveningP;
    logic [3*N-1:0] sched_mask;
    logic [N-1:0]   override;
    logic           enable;
    logic [N-1:0]   act_out, pending;
    logic           busy, alarm;
    logic [7:0]     dose_count;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a grant occupies the supply for a fixed window of edges.
    int           cyc = 0;
    int           m_free_at, m_grant_cyc, m_gidx, m_ptr, m_count;
    logic [N-1:0] m_pending, m_ov_prev;

    dispense_scheduler #(
        .N_MOD     (N),
        .PULSE_CYC (P),
        .GAP_CYC   (G)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .morningP   (morningP),
        .afternoonP (afternoonP),
        .eveningP   (eveningP),
        .sched_mask (sched_mask),
        .override   (override),
        .enable     (enable),
        .act_out    (act_out),
        .pending    (pending),
        .busy       (busy),
        .alarm      (alarm),
        .dose_count (dose_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pending   = '0;
        m_ov_prev   = '1;
        m_ptr       = N - 1;
        m_count     = 0;
        m_free_at   = 0;
        m_grant_cyc = -1000;
        m_gidx      = 0;
    endtask

    task automatic compare_all();
        logic [N-1:0] exp_act;
        logic         exp_busy;
        exp_act  = (cyc >= m_grant_cyc && cyc - m_grant_cyc < P) ? N'(1 << m_gidx) : '0;
        exp_busy = (cyc < m_free_at - 1);
        check("act_out", 32'(act_out), 32'(exp_act));
        check("pending", 32'(pending), 32'(m_pending));
        check("busy", 32'(busy), 32'(exp_busy));
        check("alarm", 32'(alarm), 32'((|m_pending) | exp_busy));
        check("dose_count", 32'(dose_count), 32'(m_count));
    endtask

    task automatic tick();
        logic [N-1:0] req;
        logic         found;
        int           idx;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            cyc++;
            for (int i = 0; i < N; i++)
                req[i] = (morningP & sched_mask[3*i]) | (afternoonP & sched_mask[3*i+1])
                       | (eveningP & sched_mask[3*i+2]) | (override[i] & ~m_ov_prev[i]);
            m_ov_prev = override;
            if (cyc >= m_free_at && enable && m_pending != '0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && m_pending[idx]) begin
                        found  = 1'b1;
                        m_gidx = idx;
                    end
                end
                m_ptr              = m_gidx;
                m_pending[m_gidx]  = 1'b0;
                m_grant_cyc        = cyc;
                m_free_at          = cyc + P + G + 1;
                if (m_count < 255) m_count++;
            end
            m_pending = m_pending | req;
        end
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; morningP = 0; afternoonP = 0; eveningP = 0;
        sched_mask = '0; override = '0; enable = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_act", 32'(act_out), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_alarm", 32'(alarm), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(dose_count), 0);
        @(negedge clk) reset = 1'b0;

        // Single module, single morning dose.
        sched_mask = 6'b000_001; enable = 1'b1;
        morningP = 1; tick(); morningP = 0;
        check("pend_after_slot", 32'(pending), 32'h1);
        repeat (10) tick();
        check("one_dose", 32'(dose_count), 1);

        // Both modules, then merged requests while disabled.
        sched_mask = 6'b001_001;
        morningP = 1; tick(); morningP = 0;
        repeat (16) tick();
        check("two_module_doses", 32'(dose_count), 3);
        enable = 0;
        morningP = 1; tick(); morningP = 0; tick();
        morningP = 1; tick(); morningP = 0;
        check("merged_pending", 32'(pending), 32'h3);
        enable = 1;
        repeat (20) tick();
        check("merged_doses", 32'(dose_count), 5);

        // Override during module 0 pulse, held for 100 cycles.
        sched_mask = 6'b000_001;
        morningP = 1; tick(); morningP = 0; tick();
        override = 2'b10;
        repeat (100) tick();
        override = '0;
        repeat (10) tick();
        check("override_once", 32'(dose_count), 7);

        // Disabled with both pending.
        enable = 0; override = 2'b11; tick(); override = '0;
        repeat (5) tick();
        check("hold_pending", 32'(pending), 32'h3);
        enable = 1;
        repeat (20) tick();

        // Async reset in the middle of a pulse.
        morningP = 1; tick(); morningP = 0; tick(); tick();
        check("pre_rst_act", 32'(act_out), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async_act", 32'(act_out), 0);
        check("async_pending", 32'(pending), 0);
        check("async_count", 32'(dose_count), 0);
        check("async_alarm", 32'(alarm), 0);
        model_reset();
        tick();
        @(negedge clk) reset = 1'b0;

        // Saturation: repeated override edges on module 0.
        sched_mask = '0; enable = 1;
        for (int i = 0; i < 2200; i++) begin
            override[0] = ~override[0];
            tick();
        end
        override = '0;
        repeat (20) tick();
        check("saturated", 32'(dose_count), 255);

        // Random traffic (count already saturated; restart from reset).
        reset = 1'b1; tick(); @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            morningP   = ($urandom_range(0, 15) == 0);
            afternoonP = ($urandom_range(0, 15) == 0);
            eveningP   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) sched_mask = 6'($urandom);
            if ($urandom_range(0, 7) == 0) override = N'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire
